// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, state encodings and small helpers for the iterative
// RV64M multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] reg_bus_t;

  localparam logic MULDIV_SIGN   = 1'b1;
  localparam logic MULDIV_UNSIGN = 1'b0;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  function automatic reg_bus_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic reg_bus_t neg64(input reg_bus_t v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide, selected
// by is_div. Purely combinational.
module muldiv_ctrl_step
  import muldiv_ctrl_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] op_a,
  input  reg_bus_t          op_b,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [2*XLEN-1:0] op_a_nxt,
  output reg_bus_t          op_b_nxt
);

  logic [XLEN:0] rem_sh_s;
  logic          fits_s;
  reg_bus_t      diff_s;

  // Divide: remainder picks up the next dividend bit from the top of op_a.
  assign rem_sh_s = {acc[XLEN-1:0], op_a[XLEN-1]};
  assign fits_s   = (rem_sh_s >= {1'b0, op_b});
  assign diff_s   = rem_sh_s[XLEN-1:0] - op_b;

  // Select the divide or multiply iteration.
  always_comb begin
    acc_nxt  = acc;
    op_a_nxt = op_a;
    op_b_nxt = op_b;
    if (is_div) begin
      acc_nxt  = {{XLEN{1'b0}}, (fits_s ? diff_s : rem_sh_s[XLEN-1:0])};
      op_a_nxt = {{XLEN{1'b0}}, op_a[XLEN-2:0], fits_s};
      op_b_nxt = op_b;
    end else begin
      acc_nxt  = op_b[0] ? (acc + op_a) : acc;
      op_a_nxt = {op_a[2*XLEN-2:0], 1'b0};
      op_b_nxt = {1'b0, op_b[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV64M multiply/divide unit: sequencing FSM, operand magnitude
// and sign handling, special-case shortcuts, and registered result pair.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rs1_sign_i,
  input  logic            rs2_sign_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_l_o,
  output logic [XLEN-1:0] result_h_o
);

  logic [1:0]        state_r, state_nxt_s;
  logic [6:0]        cnt_r, cnt_nxt_s;
  logic [2*XLEN-1:0] acc_r, acc_nxt_s, op_a_r, op_a_nxt_s;
  reg_bus_t          op_b_r, op_b_nxt_s;
  logic              div_r, div_nxt_s, word_r, word_nxt_s, special_r, special_nxt_s;
  logic              neg_q_r, neg_q_nxt_s, neg_r_r, neg_r_nxt_s;
  reg_bus_t          res_l_r, res_l_nxt_s, res_h_r, res_h_nxt_s;

  logic [2*XLEN-1:0] step_acc_s, step_op_a_s;
  reg_bus_t          step_op_b_s;
  reg_bus_t          a_ext_s, b_ext_s, a_mag_s, b_mag_s;
  logic              a_neg_s, b_neg_s, div_s, div0_s, ovf_s, unused_s;
  logic [2*XLEN-1:0] prod_s;
  reg_bus_t          quo_s, rem_s, raw_l_s, raw_h_s, fix_l_s, fix_h_s;

  assign unused_s = ^funct3_i[1:0];

  // W-variants work on the low word, sign- or zero-extended by the sign flag.
  assign a_ext_s = word_i ? (rs1_sign_i ? sext32(rs1_data_i[31:0]) : {32'd0, rs1_data_i[31:0]}) : rs1_data_i;
  assign b_ext_s = word_i ? (rs2_sign_i ? sext32(rs2_data_i[31:0]) : {32'd0, rs2_data_i[31:0]}) : rs2_data_i;
  assign a_neg_s = rs1_sign_i & a_ext_s[XLEN-1];
  assign b_neg_s = rs2_sign_i & b_ext_s[XLEN-1];
  assign a_mag_s = a_neg_s ? neg64(a_ext_s) : a_ext_s;
  assign b_mag_s = b_neg_s ? neg64(b_ext_s) : b_ext_s;
  assign div_s   = funct3_i[2];
  assign div0_s  = div_s & (b_mag_s == 64'd0);
  assign ovf_s   = div_s & rs1_sign_i & rs2_sign_i & (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF) &
                   (word_i ? (a_ext_s == sext32(32'h8000_0000)) : (a_ext_s == 64'h8000_0000_0000_0000));

  assign prod_s = neg_q_r ? (~acc_r + 128'd1) : acc_r;
  assign quo_s  = neg_q_r ? neg64(op_a_r[XLEN-1:0]) : op_a_r[XLEN-1:0];
  assign rem_s  = neg_r_r ? neg64(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];

  // Raw result pair before word narrowing; special cases were preloaded.
  always_comb begin
    raw_l_s = prod_s[XLEN-1:0];
    raw_h_s = prod_s[2*XLEN-1:XLEN];
    if (special_r) begin
      raw_l_s = op_a_r[XLEN-1:0];
      raw_h_s = acc_r[XLEN-1:0];
    end else if (div_r) begin
      raw_l_s = quo_s;
      raw_h_s = rem_s;
    end else begin
      raw_l_s = prod_s[XLEN-1:0];
      raw_h_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  assign fix_l_s = word_r ? sext32(raw_l_s[31:0]) : raw_l_s;
  assign fix_h_s = word_r ? (div_r ? sext32(raw_h_s[31:0]) : 64'd0) : raw_h_s;

  muldiv_ctrl_step u_step (
    .is_div   (div_r),
    .acc      (acc_r),
    .op_a     (op_a_r),
    .op_b     (op_b_r),
    .acc_nxt  (step_acc_s),
    .op_a_nxt (step_op_a_s),
    .op_b_nxt (step_op_b_s)
  );

  // FSM next-state and datapath register loads.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    acc_nxt_s     = acc_r;
    op_a_nxt_s    = op_a_r;
    op_b_nxt_s    = op_b_r;
    div_nxt_s     = div_r;
    word_nxt_s    = word_r;
    special_nxt_s = special_r;
    neg_q_nxt_s   = neg_q_r;
    neg_r_nxt_s   = neg_r_r;
    res_l_nxt_s   = res_l_r;
    res_h_nxt_s   = res_h_r;
    if (flush_i) begin
      state_nxt_s = MD_IDLE;
      cnt_nxt_s   = 7'd0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (req_valid_i) begin
            div_nxt_s   = div_s;
            word_nxt_s  = word_i;
            neg_q_nxt_s = a_neg_s ^ b_neg_s;
            neg_r_nxt_s = a_neg_s;
            op_b_nxt_s  = b_mag_s;
            acc_nxt_s   = {(2*XLEN){1'b0}};
            if (div0_s) begin
              special_nxt_s = 1'b1;
              op_a_nxt_s    = {{XLEN{1'b0}}, 64'hFFFF_FFFF_FFFF_FFFF};
              acc_nxt_s     = {{XLEN{1'b0}}, a_ext_s};
              cnt_nxt_s     = 7'd0;
              state_nxt_s   = MD_FIX;
            end else if (ovf_s) begin
              special_nxt_s = 1'b1;
              op_a_nxt_s    = {{XLEN{1'b0}}, a_ext_s};
              cnt_nxt_s     = 7'd0;
              state_nxt_s   = MD_FIX;
            end else begin
              special_nxt_s = 1'b0;
              // Word divides start with the dividend's bit 31 at the top.
              op_a_nxt_s    = (div_s & word_i) ? {{XLEN{1'b0}}, a_mag_s[31:0], 32'd0}
                                               : {{XLEN{1'b0}}, a_mag_s};
              cnt_nxt_s     = word_i ? 7'd32 : 7'd64;
              state_nxt_s   = MD_CALC;
            end
          end else begin
            state_nxt_s = MD_IDLE;
          end
        end
        MD_CALC: begin
          acc_nxt_s  = step_acc_s;
          op_a_nxt_s = step_op_a_s;
          op_b_nxt_s = step_op_b_s;
          cnt_nxt_s  = cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            state_nxt_s = MD_FIX;
          end else begin
            state_nxt_s = MD_CALC;
          end
        end
        MD_FIX: begin
          res_l_nxt_s = fix_l_s;
          res_h_nxt_s = fix_h_s;
          state_nxt_s = MD_DONE;
        end
        MD_DONE: begin
          state_nxt_s = MD_IDLE;
        end
        default: begin
          state_nxt_s = MD_IDLE;
          cnt_nxt_s   = 7'd0;
        end
      endcase
    end
  end

  // State, datapath and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= MD_IDLE;
      cnt_r     <= 7'd0;
      acc_r     <= {(2*XLEN){1'b0}};
      op_a_r    <= {(2*XLEN){1'b0}};
      op_b_r    <= 64'd0;
      div_r     <= 1'b0;
      word_r    <= 1'b0;
      special_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      res_l_r   <= 64'd0;
      res_h_r   <= 64'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      acc_r     <= acc_nxt_s;
      op_a_r    <= op_a_nxt_s;
      op_b_r    <= op_b_nxt_s;
      div_r     <= div_nxt_s;
      word_r    <= word_nxt_s;
      special_r <= special_nxt_s;
      neg_q_r   <= neg_q_nxt_s;
      neg_r_r   <= neg_r_nxt_s;
      res_l_r   <= res_l_nxt_s;
      res_h_r   <= res_h_nxt_s;
    end
  end

  assign stall_req_o    = rst & ~flush_i & (((state_r == MD_IDLE) & req_valid_i) |
                                            (state_r == MD_CALC) | (state_r == MD_FIX));
  assign result_valid_o = rst & ~flush_i & (state_r == MD_DONE);
  assign result_l_o     = res_l_r;
  assign result_h_o     = res_h_r;

endmodule
